// File: rtl/logic_auth_lock.sv
// Clocked password authenticator with consecutive-failure counting and timed lockout.
// Optional macro LOGIC_AUTH_BACKOFF_EN doubles the lockout per entry (up to 8x) until a grant.
module logic_auth_lock #(
  parameter int unsigned PW_WIDTH    = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid,
  input  logic [PW_WIDTH-1:0] set_pw,
  input  logic                guess_valid,
  input  logic [PW_WIDTH-1:0] guess_pw,
  input  logic                relock,
  output logic                unlocked,
  output logic                grant,
  output logic                denied,
  output logic                locked,
  output logic [3:0]          tries_left,
  output logic                armed
);

`ifdef LOGIC_AUTH_BACKOFF_EN
  localparam int unsigned TimerW = 19;
`else
  localparam int unsigned TimerW = 16;
`endif

  localparam logic [3:0]        MaxTries = 4'(MAX_TRIES);
  localparam logic [TimerW-1:0] LockBase = TimerW'(LOCK_CYCLES);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

  typedef enum logic [1:0] {StUnset, StArmed, StGranted, StLockout} state_e;

  state_e                state_q, state_d;
  logic [PW_WIDTH-1:0]   pw_q, pw_d;
  logic [3:0]            fail_q, fail_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  grant_q, grant_d;
  logic                  denied_q, denied_d;
  logic [TimerW-1:0]     lock_dur;

`ifdef LOGIC_AUTH_BACKOFF_EN
  logic [1:0] level_q, level_d;
  assign lock_dur = LockBase << level_q;
`else
  assign lock_dur = LockBase;
`endif

  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    grant_d  = 1'b0;
    denied_d = 1'b0;
`ifdef LOGIC_AUTH_BACKOFF_EN
    level_d  = level_q;
`endif
    unique case (state_q)
      StUnset: begin
        if (set_valid) begin
          pw_d    = set_pw;
          fail_d  = 4'd0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        // A concurrent set_valid is dropped: changing the password needs a grant first.
        if (guess_valid) begin
          if (guess_pw == pw_q) begin
            grant_d = 1'b1;
            fail_d  = 4'd0;
            state_d = StGranted;
`ifdef LOGIC_AUTH_BACKOFF_EN
            level_d = 2'd0;
`endif
          end else begin
            denied_d = 1'b1;
            if (fail_q + 4'd1 >= MaxTries) begin
              fail_d  = MaxTries;
              timer_d = lock_dur - TimerOne;
              state_d = StLockout;
`ifdef LOGIC_AUTH_BACKOFF_EN
              if (level_q != 2'd3) level_d = level_q + 2'd1;
`endif
            end else begin
              fail_d = fail_q + 4'd1;
            end
          end
        end
      end
      StGranted: begin
        if (set_valid) begin
          pw_d    = set_pw;
          state_d = StArmed;
        end else if (relock) begin
          state_d = StArmed;
        end
      end
      StLockout: begin
        // Timer loaded with duration-1 and exit taken on zero gives exactly duration cycles.
        if (timer_q == '0) begin
          fail_d  = 4'd0;
          state_d = StArmed;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      default: state_d = StUnset;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StUnset;
      pw_q     <= '0;
      fail_q   <= 4'd0;
      timer_q  <= '0;
      grant_q  <= 1'b0;
      denied_q <= 1'b0;
`ifdef LOGIC_AUTH_BACKOFF_EN
      level_q  <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      denied_q <= denied_d;
`ifdef LOGIC_AUTH_BACKOFF_EN
      level_q  <= level_d;
`endif
    end
  end

  assign unlocked   = (state_q == StGranted);
  assign armed      = (state_q == StArmed);
  assign locked     = (state_q == StLockout);
  assign grant      = grant_q;
  assign denied     = denied_q;
  assign tries_left = MaxTries - fail_q;

endmodule

// File: tb/tb_logic_auth_lock.sv
// Randomised bench for logic_auth_lock against a cycle-level behavioural model,
// with directed scenarios pinning exact values.
module tb_logic_auth_lock;
  localparam int MaxTries   = 3;
  localparam int LockCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       set_valid = 1'b0, guess_valid = 1'b0, relock = 1'b0;
  logic [3:0] set_pw = '0, guess_pw = '0;
  logic       unlocked, grant, denied, locked, armed;
  logic [3:0] tries_left;

  int tests = 0;
  int errors = 0;

  // Behavioural model state
  bit         m_have, m_open, m_grant, m_denied;
  logic [3:0] m_pw;
  int         m_fails, m_lock_left, m_level;

  logic_auth_lock dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (set_valid),
    .set_pw     (set_pw),
    .guess_valid(guess_valid),
    .guess_pw   (guess_pw),
    .relock     (relock),
    .unlocked   (unlocked),
    .grant      (grant),
    .denied     (denied),
    .locked     (locked),
    .tries_left (tries_left),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_have = 0; m_open = 0; m_grant = 0; m_denied = 0;
    m_pw = '0; m_fails = 0; m_lock_left = 0; m_level = 0;
  endfunction

  function automatic void model_step();
    m_grant = 0;
    m_denied = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (!m_have) begin
      if (set_valid) begin
        m_have = 1; m_pw = set_pw; m_fails = 0;
      end
    end else if (m_open) begin
      if (set_valid) begin
        m_pw = set_pw; m_open = 0;
      end else if (relock) begin
        m_open = 0;
      end
    end else if (guess_valid) begin
      if (guess_pw == m_pw) begin
        m_grant = 1; m_fails = 0; m_open = 1; m_level = 0;
      end else begin
        m_denied = 1;
        m_fails++;
        if (m_fails == MaxTries) begin
          m_lock_left = LockCycles << m_level;
`ifdef LOGIC_AUTH_BACKOFF_EN
          if (m_level < 3) m_level++;
`endif
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    check("unlocked", int'(unlocked), int'(m_open));
    check("grant", int'(grant), int'(m_grant));
    check("denied", int'(denied), int'(m_denied));
    check("locked", int'(locked), int'(m_lock_left > 0));
    check("armed", int'(armed), int'(m_have && !m_open && m_lock_left == 0));
    check("tries_left", int'(tries_left), MaxTries - m_fails);
  end

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input logic sv, input logic [3:0] sp, input logic gv,
                      input logic [3:0] gp, input logic rl);
    set_valid = sv; set_pw = sp; guess_valid = gv; guess_pw = gp; relock = rl;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset(input bit pin);
    set_valid = 0; guess_valid = 0; relock = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (pin) begin
      check("rst_unlocked", int'(unlocked), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_armed", int'(armed), 0);
      check("rst_grant_denied", int'(grant | denied), 0);
      check("rst_tries", int'(tries_left), 3);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Three wrong guesses, then count cycles spent locked (optionally guessing right meanwhile).
  task automatic lockout(input bit guess_right, output int n);
    for (int i = 0; i < MaxTries; i++) tick(1'b0, 4'h0, 1'b1, m_pw ^ 4'hF, 1'b0);
    n = 0;
    while (locked && n < 400) begin
      n++;
      tick(1'b0, 4'h0, guess_right, m_pw, 1'b0);
    end
  endtask

  int n;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Set then correct guess
    tick(1'b1, 4'b1010, 1'b0, 4'h0, 1'b0);
    check("t1_armed", int'(armed), 1);
    tick(1'b0, 4'h0, 1'b1, 4'b1010, 1'b0);
    check("t1_grant", int'(grant), 1);
    check("t1_unlocked", int'(unlocked), 1);
    check("t1_tries", int'(tries_left), 3);
    idle();
    check("t1_grant_pulse", int'(grant), 0);
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check("t1_relock", int'(armed), 1);

    // Three wrong guesses into a 16-cycle lockout; correct guesses there are ignored
    tick(1'b0, 4'h0, 1'b1, 4'b0001, 1'b0);
    check("t2_denied1", int'(denied), 1);
    check("t2_tries1", int'(tries_left), 2);
    tick(1'b0, 4'h0, 1'b1, 4'b0010, 1'b0);
    check("t2_tries2", int'(tries_left), 1);
    tick(1'b0, 4'h0, 1'b1, 4'b0011, 1'b0);
    check("t2_denied3", int'(denied), 1);
    check("t2_locked", int'(locked), 1);
    check("t2_tries3", int'(tries_left), 0);
    n = 0;
    while (locked && n < 400) begin
      n++;
      tick(1'b0, 4'h0, 1'b1, 4'b1010, 1'b0);
      check("t3_no_grant", int'(grant), 0);
    end
    check("t2_lock_len", n, 16);
    check("t2_armed_after", int'(armed), 1);
    check("t2_tries_after", int'(tries_left), 3);

    // Set while armed is dropped
    tick(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b1, 4'b1010, 1'b0);
    check("t3_old_pw_grants", int'(grant), 1);

    // Set beats relock in GRANTED
    tick(1'b1, 4'b0110, 1'b0, 4'h0, 1'b1);
    check("t4_armed", int'(armed), 1);
    tick(1'b0, 4'h0, 1'b1, 4'b1010, 1'b0);
    check("t4_old_denied", int'(denied), 1);
    tick(1'b0, 4'h0, 1'b1, 4'b0110, 1'b0);
    check("t4_new_grant", int'(grant), 1);
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Reset mid-lockout erases everything
    for (int i = 0; i < MaxTries; i++) tick(1'b0, 4'h0, 1'b1, 4'b1111, 1'b0);
    repeat (4) idle();
    check("t5_still_locked", int'(locked), 1);
    do_reset(1'b1);
    tick(1'b0, 4'h0, 1'b1, 4'b0000, 1'b0);
    check("t5_guess_ignored", int'(grant | denied | armed), 0);
    tick(1'b0, 4'h0, 1'b1, 4'b0110, 1'b0);
    check("t5_old_pw_gone", int'(grant), 0);

`ifdef LOGIC_AUTH_BACKOFF_EN
    tick(1'b1, 4'b0101, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      lockout(1'b0, n);
      check("t6_backoff_len", n, 16 << ((k < 3) ? k : 3));
    end
    tick(1'b0, 4'h0, 1'b1, 4'b0101, 1'b0);
    check("t6_grant", int'(grant), 1);
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    lockout(1'b1, n);
    check("t6_backoff_cleared", n, 16);
`else
    tick(1'b1, 4'b0101, 1'b0, 4'h0, 1'b0);
    lockout(1'b1, n);
    check("t6_fixed_len", n, 16);
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'b0);
      end else begin
        logic [3:0] gp;
        gp = ($urandom_range(0, 9) < 4) ? m_pw : 4'($urandom);
        tick(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 2) == 0), gp,
             ($urandom_range(0, 5) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
